fifo_ddr_wr_burst: RTL



---
 rtl/fifo_ddr_wr_burst.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/fifo_ddr_wr_burst.sv
// DDR write master: drains fixed-length bursts from the video FIFO read side into an AW/W/B channel,
// walking a linear frame address and flagging frame completion to the frame-buffer logic.
module fifo_ddr_wr_burst #(
    parameter int                    DATA_WIDTH   = 64,
    parameter int                    LEVEL_WIDTH  = 13,
    parameter int                    ADDR_WIDTH   = 28,
    parameter int                    BURST_LEN    = 16,
    parameter int                    FRAME_BURSTS = 4096,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      frame_start,
    output logic                      fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]     fifo_rd_data,
    input  logic                      fifo_rd_empty,
    input  logic [LEVEL_WIDTH-1:0]    fifo_rd_water_level,
    output logic [ADDR_WIDTH-1:0]     awaddr,
    output logic [7:0]                awlen,
    output logic                      awvalid,
    input  logic                      awready,
    output logic [DATA_WIDTH-1:0]     wdata,
    output logic [DATA_WIDTH/8-1:0]   wstrb,
    output logic                      wlast,
    output logic                      wvalid,
    input  logic                      wready,
    input  logic                      bvalid,
    output logic                      bready,
    output logic                      busy,
    output logic                      frame_done
);

    localparam int ISSUE_W = $clog2(BURST_LEN + 1);
    localparam int CNT_W   = $clog2(FRAME_BURSTS + 1);

    localparam logic [ADDR_WIDTH-1:0]  ADDR_STEP  = ADDR_WIDTH'(BURST_LEN * (DATA_WIDTH / 8));
    localparam logic [LEVEL_WIDTH-1:0] LEVEL_NEED = LEVEL_WIDTH'(BURST_LEN);
    localparam logic [ISSUE_W-1:0]     ISSUE_MAX  = ISSUE_W'(BURST_LEN);
    localparam logic [ISSUE_W-1:0]     ISSUE_LAST = ISSUE_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0]       CNT_LAST   = CNT_W'(FRAME_BURSTS - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t state, state_nxt;

    logic [ADDR_WIDTH-1:0] addr;
    logic [CNT_W-1:0]      burst_cnt;
    logic                  done_flag;
    logic                  start_pending;
    logic [ISSUE_W-1:0]    rd_issued;
    logic                  rd_inflight;
    logic                  inflight_last;
    logic [DATA_WIDTH-1:0] buf_data [2];
    logic [1:0]            buf_last;
    logic                  buf_wr_ptr;
    logic                  buf_rd_ptr;
    logic [1:0]            buf_cnt;

    logic buf_valid;
    logic w_pop;
    logic rd_room;
    logic restart;
    logic burst_go;

    assign buf_valid = (buf_cnt != 2'd0);
    assign w_pop     = (state == DATA) && buf_valid && wready;

    // Room is judged after this cycle's pop so a steady wready sustains one beat per clock.
    assign rd_room   = ({1'b0, buf_cnt} + {2'b00, rd_inflight}) < (3'd2 + {2'b00, w_pop});

    // A pending or fresh frame_start wins over launching a burst from IDLE.
    assign restart   = (state == IDLE) && (frame_start || start_pending);
    assign burst_go  = (state == IDLE) && !restart && !done_flag &&
                       (fifo_rd_water_level >= LEVEL_NEED);

    assign awaddr = addr;
    assign awlen  = 8'(BURST_LEN - 1);
    assign wstrb  = '1;
    assign wdata  = buf_data[buf_rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (burst_go) state_nxt = ADDR;
            ADDR:    if (awready) state_nxt = DATA;
            DATA:    if (w_pop && buf_last[buf_rd_ptr]) state_nxt = RESP;
            RESP:    if (bvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case so no latch is inferred.
    always_comb begin
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        bready     = 1'b0;
        fifo_rd_en = 1'b0;
        busy       = (state != IDLE);
        case (state)
            ADDR: awvalid = 1'b1;
            DATA: begin
                wvalid     = buf_valid;
                fifo_rd_en = (rd_issued < ISSUE_MAX) && !fifo_rd_empty && rd_room;
            end
            RESP: bready = 1'b1;
            default: ;
        endcase
    end

    assign wlast = wvalid && buf_last[buf_rd_ptr];

    // NOTE: the two skid entries are reset so wdata reads zero out of reset; deeper storage would not be.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr          <= BASE_ADDR;
            burst_cnt     <= '0;
            done_flag     <= 1'b0;
            start_pending <= 1'b0;
            frame_done    <= 1'b0;
            rd_issued     <= '0;
            rd_inflight   <= 1'b0;
            inflight_last <= 1'b0;
            buf_data[0]   <= '0;
            buf_data[1]   <= '0;
            buf_last      <= '0;
            buf_wr_ptr    <= 1'b0;
            buf_rd_ptr    <= 1'b0;
            buf_cnt       <= '0;
        end else begin
            frame_done <= 1'b0;

            if (restart) begin
                addr          <= BASE_ADDR;
                burst_cnt     <= '0;
                done_flag     <= 1'b0;
                start_pending <= 1'b0;
            end else if (frame_start && (state != IDLE)) begin
                start_pending <= 1'b1;
            end

            if ((state == RESP) && bvalid) begin
                addr      <= addr + ADDR_STEP;
                burst_cnt <= burst_cnt + CNT_W'(1);
                if (burst_cnt == CNT_LAST) begin
                    done_flag  <= 1'b1;
                    frame_done <= 1'b1;
                end
            end

            rd_inflight <= fifo_rd_en;
            if (state == ADDR) begin
                rd_issued <= '0;
            end else if (fifo_rd_en) begin
                rd_issued     <= rd_issued + ISSUE_W'(1);
                inflight_last <= (rd_issued == ISSUE_LAST);
            end

            // FIFO data is valid the cycle after the read strobe; capture it then.
            if (rd_inflight) begin
                buf_data[buf_wr_ptr] <= fifo_rd_data;
                buf_last[buf_wr_ptr] <= inflight_last;
                buf_wr_ptr           <= ~buf_wr_ptr;
            end
            if (w_pop) begin
                buf_rd_ptr <= ~buf_rd_ptr;
            end
            buf_cnt <= buf_cnt + {1'b0, rd_inflight} - {1'b0, w_pop};
        end
    end

endmodule
